// File: rtl/byte_serializer_pkg.sv
// Shared types, widths and elaboration helpers for the byte serializer.
package byte_serializer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  function automatic bit params_legal(input int bit_period, input int gap_cycles);
    return (bit_period >= 1) && (gap_cycles >= 0);
  endfunction

  // Counters sized by $clog2 collapse to zero bits for trivial ranges; keep one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_serializer_bit_timer.sv
// Bit-period divider: raises tick on the last clk of each serial bit while run is high.
module bit_timer #(
  parameter int BIT_PERIOD = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic tick
);
  import byte_serializer_pkg::*;

  localparam int W = cnt_width(BIT_PERIOD);
  localparam logic [W-1:0] LAST = W'(BIT_PERIOD - 1);

  logic [W-1:0] div_cnt;

  assign tick = run && (div_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial stage: one-byte holding buffer feeding an MSB-first shifter
// with a shift strobe per bit and a byte_done pulse after the eighth strobe.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int BIT_PERIOD = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_data,
  output logic              ser_shift_enable,
  output logic              byte_done,
  output logic              busy
);

  if (!params_legal(BIT_PERIOD, GAP_CYCLES)) begin : g_bad_params
    $error("byte_serializer: BIT_PERIOD must be >= 1 and GAP_CYCLES >= 0");
  end

  localparam int GW = cnt_width(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state;
  state_t            state_next;
  logic [BYTE_W-1:0] hold_data;
  logic              hold_full;
  logic [BYTE_W-1:0] sh;
  logic [2:0]        bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              tick;
  logic              accept;
  logic              last_bit;
  logic              load;
  logic              gap_done;

  assign accept   = in_valid && in_ready;
  assign last_bit = tick && (bit_cnt == 3'd7);
  assign gap_done = (state == GAP) && (gap_cnt == GAP_LAST);
  // Reload straight from the eighth strobe only when no gap is configured.
  assign load     = hold_full && ((state == IDLE) || (last_bit && (GAP_CYCLES == 0)));

  assign in_ready = !hold_full;
  assign busy     = (state != IDLE) || hold_full;

  bit_timer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_bit_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (state == SHIFT),
    .clear  (load),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (hold_full) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (GAP_CYCLES > 0) begin
            state_next = GAP;
          end else if (!hold_full) begin
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ser_data         = 1'b0;
    ser_shift_enable = 1'b0;
    if (state == SHIFT) begin
      ser_data         = sh[BYTE_W-1];
      ser_shift_enable = tick;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      sh        <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= last_bit;
      if (accept) begin
        hold_data <= in_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        sh      <= hold_data;
        bit_cnt <= '0;
      end else if (tick) begin
        sh      <= {sh[BYTE_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == GAP) begin
        gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Scoreboarded bench for byte_serializer: lane 0 runs BIT_PERIOD=1/GAP=0,
// lane 1 runs BIT_PERIOD=4/GAP=3; each lane feeds a model downstream shift register.
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data          [2];
  logic       in_valid         [2];
  logic       in_ready         [2];
  logic       ser_data         [2];
  logic       ser_shift_enable [2];
  logic       byte_done        [2];
  logic       busy             [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int BP  = (g == 0) ? 1 : 4;
    localparam int GAP = (g == 0) ? 0 : 3;

    logic [7:0] down;
    logic [7:0] pend_q[$];
    logic [7:0] done_q[$];
    int         strobe_q[$];
    int         done_cyc_q[$];
    int         hs_q[$];
    int         cyc = 0;
    int         idx = 0;
    bit         due = 1'b0;
    logic [7:0] cur;

    byte_serializer #(
      .BIT_PERIOD(BP),
      .GAP_CYCLES(GAP)
    ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .in_data         (in_data[g]),
      .in_valid        (in_valid[g]),
      .in_ready        (in_ready[g]),
      .ser_data        (ser_data[g]),
      .ser_shift_enable(ser_shift_enable[g]),
      .byte_done       (byte_done[g]),
      .busy            (busy[g])
    );

    // Downstream serial-in register sharing the serializer's reset.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        down <= '0;
      end else if (ser_shift_enable[g]) begin
        down <= {down[6:0], ser_data[g]};
      end
    end

    // Monitor: bytes enter the model at the handshake, leave MSB-first on strobes,
    // and must appear whole in the downstream register on the byte_done pulse.
    always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
        pend_q.delete();
        done_q.delete();
        idx = 0;
        due = 1'b0;
      end else begin
        if (byte_done[g] || due) begin
          check_output($sformatf("lane%0d byte_done timing", g), 32'(byte_done[g]), 32'(due));
        end
        if (byte_done[g]) begin
          done_cyc_q.push_back(cyc);
          if (done_q.size() != 0) begin
            check_output($sformatf("lane%0d captured byte", g), 32'(down), 32'(done_q.pop_front()));
          end
        end
        due = 1'b0;
        if (ser_shift_enable[g]) begin
          strobe_q.push_back(cyc);
          if (pend_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL lane%0d unexpected strobe: actual strobe, required none", g);
          end else begin
            cur = pend_q[0];
            check_output($sformatf("lane%0d ser_data bit %0d", g, idx), 32'(ser_data[g]), 32'(cur[7-idx]));
            idx++;
            if (idx == 8) begin
              done_q.push_back(pend_q.pop_front());
              idx = 0;
              due = 1'b1;
            end
          end
        end
        if (in_valid[g] && in_ready[g]) begin
          pend_q.push_back(in_data[g]);
          hs_q.push_back(cyc);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the byte,
  // leaving in_valid high so a following call forms a back-to-back stream.
  task automatic apply_stimulus(input int lane, input logic [7:0] d);
    int waited = 0;
    in_valid[lane] = 1'b1;
    in_data[lane]  = d;
    @(negedge clk);
    while (!in_ready[lane] && waited < 400) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      waited++;
    end
    if (!in_ready[lane]) begin
      checks++;
      errors++;
      $display("[TB] FAIL lane%0d handshake: in_ready stuck at 0, required 1 within 400 cycles", lane);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_records();
    g_lane[0].strobe_q.delete();
    g_lane[0].done_cyc_q.delete();
    g_lane[0].hs_q.delete();
    g_lane[1].strobe_q.delete();
    g_lane[1].done_cyc_q.delete();
    g_lane[1].hs_q.delete();
  endtask

  function automatic int outstanding(input int lane);
    if (lane == 0) return g_lane[0].pend_q.size() + g_lane[0].done_q.size();
    return g_lane[1].pend_q.size() + g_lane[1].done_q.size();
  endfunction

  task automatic drain(input int lane);
    int n = 0;
    while ((outstanding(lane) != 0 || busy[lane]) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output($sformatf("lane%0d drained", lane), 32'(outstanding(lane)), 32'd0);
  endtask

  task automatic check_reset_outputs(input int lane);
    check_output($sformatf("lane%0d reset in_ready", lane), 32'(in_ready[lane]), 32'd1);
    check_output($sformatf("lane%0d reset ser_data", lane), 32'(ser_data[lane]), 32'd0);
    check_output($sformatf("lane%0d reset strobe", lane), 32'(ser_shift_enable[lane]), 32'd0);
    check_output($sformatf("lane%0d reset byte_done", lane), 32'(byte_done[lane]), 32'd0);
    check_output($sformatf("lane%0d reset busy", lane), 32'(busy[lane]), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: actual still running, required finish within 30000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    int         h;
    int         n;
    int         sent;
    bit         consecutive;

    reset_n = 1'b0;
    for (int l = 0; l < 2; l++) begin
      in_valid[l] = 1'b0;
      in_data[l]  = 8'h00;
    end
    wait_cycles(3);
    check_reset_outputs(0);
    check_reset_outputs(1);
    reset_n = 1'b1;
    wait_cycles(2);

    $display("[TB] single byte 0xA5 on lane 0");
    clear_records();
    pat = 8'hA5;
    apply_stimulus(0, pat);
    in_valid[0] = 1'b0;
    @(negedge clk);
    check_output("A5 cycle1 in_ready", 32'(in_ready[0]), 32'd0);
    check_output("A5 cycle1 busy", 32'(busy[0]), 32'd1);
    check_output("A5 cycle1 strobe", 32'(ser_shift_enable[0]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check_output($sformatf("A5 strobe cycle %0d", k + 2), 32'(ser_shift_enable[0]), 32'd1);
      check_output($sformatf("A5 ser_data cycle %0d", k + 2), 32'(ser_data[0]), 32'(pat[7-k]));
      if (k == 0) check_output("A5 cycle2 in_ready", 32'(in_ready[0]), 32'd1);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("A5 cycle10 byte_done", 32'(byte_done[0]), 32'd1);
    check_output("A5 cycle10 busy", 32'(busy[0]), 32'd0);
    wait_cycles(2);
    check_output("A5 downstream", 32'(g_lane[0].down), 32'hA5);
    check_output("A5 done count", 32'(g_lane[0].done_cyc_q.size()), 32'd1);
    check_output("A5 done cycle", 32'(g_lane[0].done_cyc_q[0] - g_lane[0].hs_q[0]), 32'd10);

    $display("[TB] back-to-back 0x3C, 0xC3 on lane 0");
    clear_records();
    apply_stimulus(0, 8'h3C);
    apply_stimulus(0, 8'hC3);
    in_valid[0] = 1'b0;
    wait_cycles(20);
    h = g_lane[0].hs_q[0];
    consecutive = (g_lane[0].strobe_q.size() == 16);
    foreach (g_lane[0].strobe_q[i]) begin
      if (g_lane[0].strobe_q[i] != h + 2 + i) consecutive = 1'b0;
    end
    check_output("b2b 16 consecutive strobes", 32'(consecutive), 32'd1);
    check_output("b2b done count", 32'(g_lane[0].done_cyc_q.size()), 32'd2);
    check_output("b2b first done", 32'(g_lane[0].done_cyc_q[0] - h), 32'd10);
    check_output("b2b second done", 32'(g_lane[0].done_cyc_q[1] - h), 32'd18);

    $display("[TB] buffer full with three bytes on lane 0");
    clear_records();
    apply_stimulus(0, 8'h01);
    apply_stimulus(0, 8'h02);
    apply_stimulus(0, 8'h03);
    in_valid[0] = 1'b0;
    wait_cycles(30);
    h = g_lane[0].hs_q[0];
    check_output("full hs count", 32'(g_lane[0].hs_q.size()), 32'd3);
    check_output("full second hs", 32'(g_lane[0].hs_q[1] - h), 32'd2);
    check_output("full third hs", 32'(g_lane[0].hs_q[2] - h), 32'd10);
    check_output("full done count", 32'(g_lane[0].done_cyc_q.size()), 32'd3);

    $display("[TB] BIT_PERIOD=4 GAP=3 byte 0x81 on lane 1");
    clear_records();
    apply_stimulus(1, 8'h81);
    in_valid[1] = 1'b0;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      if (c >= 34 && c <= 36) check_output($sformatf("gap busy cycle %0d", c), 32'(busy[1]), 32'd1);
      if (c == 37) check_output("gap idle busy", 32'(busy[1]), 32'd0);
      @(posedge clk);
      #1;
    end
    h = g_lane[1].hs_q[0];
    consecutive = (g_lane[1].strobe_q.size() == 8);
    foreach (g_lane[1].strobe_q[i]) begin
      if (g_lane[1].strobe_q[i] != h + 1 + 4 * (i + 1)) consecutive = 1'b0;
    end
    check_output("bp4 strobe schedule", 32'(consecutive), 32'd1);
    check_output("bp4 done cycle", 32'(g_lane[1].done_cyc_q[0] - h), 32'd34);
    check_output("bp4 downstream", 32'(g_lane[1].down), 32'h81);

    $display("[TB] reset during 0xFF with a byte held on lane 0");
    clear_records();
    apply_stimulus(0, 8'hFF);
    apply_stimulus(0, 8'h77);
    in_valid[0] = 1'b0;
    n = 0;
    while (g_lane[0].strobe_q.size() < 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("pre-reset strobes seen", 32'(g_lane[0].strobe_q.size()), 32'd3);
    check_output("pre-reset 4th strobe active", 32'(ser_shift_enable[0]), 32'd1);
    check_output("pre-reset byte held", 32'(in_ready[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs(0);
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(20);
    check_output("reset no byte_done", 32'(g_lane[0].done_cyc_q.size()), 32'd0);
    check_output("reset downstream cleared", 32'(g_lane[0].down), 32'h00);
    apply_stimulus(0, 8'h5A);
    in_valid[0] = 1'b0;
    wait_cycles(15);
    check_output("post-reset done count", 32'(g_lane[0].done_cyc_q.size()), 32'd1);
    check_output("post-reset downstream", 32'(g_lane[0].down), 32'h5A);

    $display("[TB] random traffic on both lanes");
    for (int l = 0; l < 2; l++) begin
      clear_records();
      sent = 0;
      for (int b = 0; b < ((l == 0) ? 30 : 10); b++) begin
        n = $urandom_range(0, 3);
        if (n > 0) begin
          in_valid[l] = 1'b0;
          wait_cycles(n);
        end
        apply_stimulus(l, 8'($urandom));
        sent++;
      end
      in_valid[l] = 1'b0;
      drain(l);
      n = (l == 0) ? g_lane[0].done_cyc_q.size() : g_lane[1].done_cyc_q.size();
      check_output($sformatf("lane%0d random byte count", l), 32'(n), 32'(sent));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
